// File: rtl/bird_convert_2_display.sv
// Bird physics and bird-layer renderer for the FlappyBird VGA pipeline.
// Define BIRD_INVINCIBLE_EN to make pipe overlap harmless (ground still kills).
module bird_convert_2_display #(
    parameter int BIRD_X    = 160,
    parameter int BIRD_SIZE = 16,
    parameter int Y_INIT    = 232,
    parameter int GROUND_Y  = 400,
    parameter int GRAVITY   = 1,
    parameter int FLAP_VEL  = -8,
    parameter int MAX_FALL  = 8,
    parameter int PHYS_DIV  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_ms,
    input  logic       up_button,
    input  logic [1:0] state,
    input  logic [1:0] pipeInfo,
    output logic [3:0] RGB_R,
    output logic [3:0] RGB_G,
    output logic [3:0] RGB_B,
    output logic       isDead
);

    localparam logic [9:0] H_LAST = 10'd799;
    localparam logic [9:0] V_LAST = 10'd524;
    localparam logic [9:0] H_ACT  = 10'd640;
    localparam logic [9:0] V_ACT  = 10'd480;

    localparam logic [9:0] BX_LO = 10'(BIRD_X);
    localparam logic [9:0] BX_HI = 10'(BIRD_X + BIRD_SIZE);
    localparam logic [9:0] BSZ   = 10'(BIRD_SIZE);
    localparam logic [9:0] Y_RST = 10'(Y_INIT);
    localparam logic [9:0] Y_MAX = 10'(GROUND_Y - BIRD_SIZE);

    localparam logic signed [7:0] GRAV = 8'(GRAVITY);
    localparam logic signed [7:0] FLAP = 8'(FLAP_VEL);
    localparam logic signed [7:0] MAXF = 8'(MAX_FALL);

    localparam int DW = $clog2(PHYS_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(PHYS_DIV - 1);

    localparam logic [11:0] C_BIRD   = 12'hFD0;
    localparam logic [11:0] C_PIPE   = 12'h0C0;
    localparam logic [11:0] C_GROUND = 12'h852;
    localparam logic [11:0] C_SKY    = 12'h4CE;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_OVER  = 2'b10,
        ST_PAUSE = 2'b11
    } game_t;

    game_t gs;
    logic  playing;
    logic  idle;

    assign gs      = game_t'(state);
    assign playing = (gs == ST_PLAY);
    assign idle    = (gs == ST_IDLE);

    logic [9:0] h;
    logic [9:0] v;

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    // [1:0] is the synchroniser, [2] remembers the previous level for edges
    logic [2:0] ms_sr;
    logic [2:0] btn_sr;
    logic       ms_rise;
    logic       btn_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_sr  <= '0;
            btn_sr <= '0;
        end else begin
            ms_sr  <= {ms_sr[1:0], clk_ms};
            btn_sr <= {btn_sr[1:0], up_button};
        end
    end

    assign ms_rise  = ms_sr[1] & ~ms_sr[2];
    assign btn_rise = btn_sr[1] & ~btn_sr[2];

    logic [DW-1:0] div;
    logic          step;

    assign step = playing && ms_rise && (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst || !playing) begin
            div <= '0;
        end else if (ms_rise) begin
            div <= step ? '0 : div + 1'b1;
        end
    end

    logic flap_req;

    always_ff @(posedge clk) begin
        if (rst || !playing) begin
            flap_req <= 1'b0;
        end else if (step) begin
            flap_req <= btn_rise;
        end else if (btn_rise) begin
            flap_req <= 1'b1;
        end
    end

    logic [9:0]        bird_y;
    logic signed [7:0] vel;
    logic signed [7:0] vel_inc;
    logic signed [7:0] vel_nx;
    logic [11:0]       y_sum;
    logic [9:0]        y_nx;

    always_comb begin
        vel_inc = vel + GRAV;
        if (flap_req) begin
            vel_nx = FLAP;
        end else if (vel_inc > MAXF) begin
            vel_nx = MAXF;
        end else begin
            vel_nx = vel_inc;
        end
        // 12-bit two's-complement sum: bit 11 flags a move above row 0
        y_sum = {2'b00, bird_y} + {{4{vel_nx[7]}}, vel_nx};
        if (y_sum[11]) begin
            y_nx = '0;
        end else if (y_sum > {2'b00, Y_MAX}) begin
            y_nx = Y_MAX;
        end else begin
            y_nx = y_sum[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            bird_y <= Y_RST;
            vel    <= '0;
        end else if (step) begin
            bird_y <= y_nx;
            vel    <= vel_nx;
        end
    end

    logic active;
    logic bird_pix;
    logic hit;
    logic at_ground;

    assign active   = (h < H_ACT) && (v < V_ACT);
    assign bird_pix = (h >= BX_LO) && (h < BX_HI) &&
                      (v >= bird_y) && (v < bird_y + BSZ);
    assign at_ground = (bird_y >= Y_MAX);

`ifdef BIRD_INVINCIBLE_EN
    assign hit = bird_pix & pipeInfo[1];
`else
    assign hit = bird_pix & (pipeInfo[0] | pipeInfo[1]);
`endif

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            isDead <= 1'b0;
        end else if (playing && (hit || at_ground)) begin
            isDead <= 1'b1;
        end
    end

    logic [11:0] rgb_nx;
    logic [11:0] rgb_q;

    always_comb begin
        rgb_nx = '0;
        if (active) begin
            if (bird_pix) begin
                rgb_nx = C_BIRD;
            end else if (pipeInfo[0]) begin
                rgb_nx = C_PIPE;
            end else if (pipeInfo[1]) begin
                rgb_nx = C_GROUND;
            end else begin
                rgb_nx = C_SKY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_nx;
        end
    end

    assign RGB_R = rgb_q[11:8];
    assign RGB_G = rgb_q[7:4];
    assign RGB_B = rgb_q[3:0];

endmodule

// File: tb/tb_bird_convert_2_display.sv
// Directed bench for bird_convert_2_display: scan colours, physics,
// flaps, clamps, pause/over freezing and death handling.
module tb_bird_convert_2_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_ms = 1'b0;
    logic       up_button = 1'b0;
    logic [1:0] state = 2'b00;
    logic [1:0] pipeInfo = 2'b00;
    logic [3:0] RGB_R;
    logic [3:0] RGB_G;
    logic [3:0] RGB_B;
    logic       isDead;

    int errs = 0;
    int checks = 0;
    int pix = 0;

`ifdef BIRD_INVINCIBLE_EN
    localparam int PIPE_KILLS = 0;
`else
    localparam int PIPE_KILLS = 1;
`endif

    bird_convert_2_display dut (
        .clk      (clk),
        .rst      (rst),
        .clk_ms   (clk_ms),
        .up_button(up_button),
        .state    (state),
        .pipeInfo (pipeInfo),
        .RGB_R    (RGB_R),
        .RGB_G    (RGB_G),
        .RGB_B    (RGB_B),
        .isDead   (isDead)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pix++;
    endtask

    task automatic ms_edges(input int n);
        repeat (n) begin
            clk_ms = 1'b1;
            repeat (3) tick();
            clk_ms = 1'b0;
            repeat (3) tick();
        end
    endtask

    task automatic steps(input int n);
        ms_edges(20 * n);
    endtask

    task automatic flap();
        up_button = 1'b1;
        repeat (3) tick();
        up_button = 1'b0;
        repeat (3) tick();
    endtask

    task automatic goto(input int hh, input int vv);
        int t;
        t = vv * 800 + hh;
        if (pix > t) chk("goto_late", pix, t);
        while (pix < t) tick();
    endtask

    task automatic pixel(input string tag, input int hh, input int vv,
                         input logic [1:0] pi, input int exp);
        goto(hh, vv);
        pipeInfo = pi;
        tick();
        pipeInfo = 2'b00;
        chk(tag, int'({RGB_R, RGB_G, RGB_B}), exp);
    endtask

    task automatic phys(input string tag, input int y, input int vl);
        chk({tag, "_y"}, int'(dut.bird_y), y);
        chk({tag, "_vel"}, int'(dut.vel), vl);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pix = 0;

        chk("rst_rgb", int'({RGB_R, RGB_G, RGB_B}), 0);
        chk("rst_dead", int'(isDead), 0);
        phys("rst", 232, 0);

        pixel("sky_0_0", 0, 0, 2'b00, 'h4CE);
        pixel("pipe", 1, 0, 2'b01, 'h0C0);
        pixel("ground", 2, 0, 2'b10, 'h852);
        pixel("pipe_over_gnd", 3, 0, 2'b11, 'h0C0);
        pixel("sky_639", 639, 0, 2'b00, 'h4CE);
        pixel("blank_640", 640, 0, 2'b01, 0);
        pixel("blank_700", 700, 0, 2'b11, 0);

        state = 2'b01;
        steps(1);
        phys("fall1", 233, 1);
        steps(1);
        phys("fall2", 235, 2);
        steps(1);
        phys("fall3", 238, 3);
        flap();
        steps(1);
        phys("flap1", 230, -8);
        repeat (30) begin
            flap();
            steps(1);
        end
        phys("top_clamp", 0, -8);

        pixel("bird_top", 165, 8, 2'b00, 'hFD0);
        pixel("left_out", 159, 10, 2'b00, 'h4CE);
        pixel("left_in", 160, 10, 2'b00, 'hFD0);
        pixel("right_in", 175, 10, 2'b00, 'hFD0);
        pixel("right_out", 176, 10, 2'b00, 'h4CE);
        chk("alive_pre_pipe", int'(isDead), 0);
        pixel("bird_over_pipe", 168, 12, 2'b01, 'hFD0);
        chk("pipe_dead", int'(isDead), PIPE_KILLS);
        pixel("below_bird", 165, 16, 2'b00, 'h4CE);

        state = 2'b10;
        repeat (3) tick();
        chk("over_dead_sticky", int'(isDead), PIPE_KILLS);
        steps(1);
        phys("over_frozen", 0, -8);

        state = 2'b00;
        repeat (2) tick();
        chk("idle_clear", int'(isDead), 0);
        phys("idle", 232, 0);

        state = 2'b01;
        steps(1);
        phys("replay", 233, 1);
        state = 2'b11;
        flap();
        ms_edges(100);
        phys("pause", 233, 1);
        state = 2'b01;
        steps(1);
        phys("no_pause_flap", 235, 2);

        steps(20);
        phys("near_gnd", 380, 8);
        chk("alive_380", int'(isDead), 0);
        steps(1);
        phys("gnd_clamp", 384, 8);
        chk("gnd_dead", int'(isDead), 1);
        steps(1);
        phys("gnd_hold", 384, 8);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        pix = 0;
        chk("rst2_h", int'(dut.h), 0);
        chk("rst2_v", int'(dut.v), 0);
        chk("rst2_rgb", int'({RGB_R, RGB_G, RGB_B}), 0);
        chk("rst2_dead", int'(isDead), 0);
        phys("rst2", 232, 0);
        pixel("rst2_sky", 0, 0, 2'b00, 'h4CE);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
